hlcp_sync_filt: RTL

Parametrised multi-channel input conditioner for HLCP lines (SCL, SDA, plus optional extra lines such as interrupt or alert). Each channel passes through a configurable-depth synchronizer and then a programmable glitch filter that suppresses pulses shorter than a runtime length. Optional edge-pulse outputs are provided. Sits between the pad inputs and the HLCP master/slave controllers in the sys_clk domain.

---
 rtl/hlcp_pkg.sv | 12 +
 rtl/hlcp_glitch_filt.sv | 69 ++++++
 rtl/hlcp_sync_filt.sv | 61 ++++++
 3 files changed

// File: rtl/hlcp_pkg.sv
// Shared HLCP constants: synchronizer depth limits, channel indices and default filter width.
package hlcp_pkg;

   localparam int unsigned HLCP_SYNC_STAGES_MIN = 2;
   localparam int unsigned HLCP_SYNC_STAGES_MAX = 4;

   localparam int unsigned HLCP_CH_SCL = 0;
   localparam int unsigned HLCP_CH_SDA = 1;

   localparam int unsigned HLCP_FILT_W = 4;

endpackage

// File: rtl/hlcp_glitch_filt.sv
// One-channel glitch filter: output follows the synchronized sample only after it has
// differed for filt_len+1 consecutive cycles. Edge pulse registers exist with HLCP_SYNC_EDGE_EN.
module hlcp_glitch_filt #(
   parameter int unsigned FILT_W  = 4,
   parameter logic        RST_VAL = 1'b1
) (
   input  logic              sys_clk,
   input  logic              sys_resetb,
   input  logic              filt_en,
   input  logic [FILT_W-1:0] filt_len,
   input  logic              s,
   output logic              dout
`ifdef HLCP_SYNC_EDGE_EN
   ,
   output logic              dout_rise,
   output logic              dout_fall
`endif
);

   logic [FILT_W-1:0] cnt_q, cnt_d;
   logic              dout_q, dout_d;

   // The >= compare lets a lowered filt_len take effect on the next differing sample.
   always_comb begin
      dout_d = dout_q;
      cnt_d  = cnt_q;
      if (!filt_en) begin
         dout_d = s;
         cnt_d  = '0;
      end else if (s == dout_q) begin
         cnt_d = '0;
      end else if (cnt_q >= filt_len) begin
         dout_d = s;
         cnt_d  = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_resetb) begin
      if (!sys_resetb) begin
         cnt_q  <= '0;
         dout_q <= RST_VAL;
      end else begin
         cnt_q  <= cnt_d;
         dout_q <= dout_d;
      end
   end

   assign dout = dout_q;

`ifdef HLCP_SYNC_EDGE_EN
   logic rise_q, fall_q;

   always_ff @(posedge sys_clk or negedge sys_resetb) begin
      if (!sys_resetb) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= dout_d & ~dout_q;
         fall_q <= ~dout_d & dout_q;
      end
   end

   assign dout_rise = rise_q;
   assign dout_fall = fall_q;
`endif

endmodule

// File: rtl/hlcp_sync_filt.sv
// Multi-channel HLCP input conditioner: per-channel synchronizer chain feeding a glitch filter.
// Optional dout_rise/dout_fall edge pulses are built when HLCP_SYNC_EDGE_EN is defined.
module hlcp_sync_filt
   import hlcp_pkg::*;
#(
   parameter int unsigned       CH_NUM      = 2,
   parameter int unsigned       SYNC_STAGES = 2,
   parameter int unsigned       FILT_W      = HLCP_FILT_W,
   parameter logic [CH_NUM-1:0] RST_VAL     = {CH_NUM{1'b1}}
) (
   input  logic              sys_clk,
   input  logic              sys_resetb,
   input  logic              filt_en,
   input  logic [FILT_W-1:0] filt_len,
   input  logic [CH_NUM-1:0] din,
   output logic [CH_NUM-1:0] dout
`ifdef HLCP_SYNC_EDGE_EN
   ,
   output logic [CH_NUM-1:0] dout_rise,
   output logic [CH_NUM-1:0] dout_fall
`endif
);

   if (SYNC_STAGES < HLCP_SYNC_STAGES_MIN || SYNC_STAGES > HLCP_SYNC_STAGES_MAX) begin : g_bad_stages
      $error("hlcp_sync_filt: SYNC_STAGES must be in 2..4");
   end

   // Stage 0 captures the pad; the last stage is the filter sample.
   logic [SYNC_STAGES-1:0][CH_NUM-1:0] sync_q;
   logic [CH_NUM-1:0]                  s;

   always_ff @(posedge sys_clk or negedge sys_resetb) begin
      if (!sys_resetb) begin
         sync_q <= {SYNC_STAGES{RST_VAL}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
      hlcp_glitch_filt #(
         .FILT_W  (FILT_W),
         .RST_VAL (RST_VAL[c])
      ) u_filt (
         .sys_clk    (sys_clk),
         .sys_resetb (sys_resetb),
         .filt_en    (filt_en),
         .filt_len   (filt_len),
         .s          (s[c]),
         .dout       (dout[c])
`ifdef HLCP_SYNC_EDGE_EN
         ,
         .dout_rise  (dout_rise[c]),
         .dout_fall  (dout_fall[c])
`endif
      );
   end

endmodule
